// File: rtl/alu_result_sel_reg.sv
// Registered NUM_IN-way result selector with a valid/ready output stage,
// a one-entry skid buffer and a saturating count of out-of-range selects.
module alu_result_sel_reg #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 11,
    parameter int SEL_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_illegal,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        illegal_cnt
);

    logic [WIDTH-1:0]  chan [NUM_IN];
    logic [NUM_IN-1:0] hit;
    logic [WIDTH-1:0]  sel_data;
    logic              sel_illegal;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
            assign chan[gi] = in_data[gi*WIDTH +: WIDTH];
            assign hit[gi]  = (in_sel == SEL_W'(gi));
        end
    endgenerate

    // One-hot AND-OR mux; an out-of-range code matches nothing and yields zero.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (hit[k]) sel_data = sel_data | chan[k];
        end
        sel_illegal = ~|hit;
    end

    logic             or_valid_q, or_valid_d;
    logic [WIDTH-1:0] or_data_q,  or_data_d;
    logic             or_ill_q,   or_ill_d;
    logic             sk_valid_q, sk_valid_d;
    logic [WIDTH-1:0] sk_data_q,  sk_data_d;
    logic             sk_ill_q,   sk_ill_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             accept;
    logic             pop;

    always_comb begin
        accept     = in_valid & ~sk_valid_q;
        pop        = or_valid_q & out_ready;
        or_valid_d = or_valid_q;
        or_data_d  = or_data_q;
        or_ill_d   = or_ill_q;
        sk_valid_d = sk_valid_q;
        sk_data_d  = sk_data_q;
        sk_ill_d   = sk_ill_q;
        cnt_d      = cnt_q;

        if (sk_valid_q && pop) begin
            or_data_d  = sk_data_q;
            or_ill_d   = sk_ill_q;
            sk_valid_d = 1'b0;
        end else if (accept && (!or_valid_q || pop)) begin
            or_valid_d = 1'b1;
            or_data_d  = sel_data;
            or_ill_d   = sel_illegal;
        end else if (accept) begin
            sk_valid_d = 1'b1;
            sk_data_d  = sel_data;
            sk_ill_d   = sel_illegal;
        end else if (pop) begin
            or_valid_d = 1'b0;
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (accept && sel_illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            or_valid_q <= 1'b0;
            or_data_q  <= '0;
            or_ill_q   <= 1'b0;
            sk_valid_q <= 1'b0;
            sk_data_q  <= '0;
            sk_ill_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            or_valid_q <= or_valid_d;
            or_data_q  <= or_data_d;
            or_ill_q   <= or_ill_d;
            sk_valid_q <= sk_valid_d;
            sk_data_q  <= sk_data_d;
            sk_ill_q   <= sk_ill_d;
            cnt_q      <= cnt_d;
        end
    end

    // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally.
    assign in_ready    = ~sk_valid_q;
    assign out_valid   = or_valid_q;
    assign out_data    = or_data_q;
    assign out_illegal = or_ill_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_result_sel_reg.sv
// Table-driven directed vectors plus a randomized run against a queue-based
// reference model of the selector stage.
module tb_alu_result_sel_reg;

    localparam int WIDTH  = 8;
    localparam int NUM_IN = 11;
    localparam int SEL_W  = 4;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                    clk;
    logic                    rst;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_illegal;
    logic                    out_valid;
    logic                    out_ready;
    logic                    cnt_clr;
    logic [CNT_W-1:0]        illegal_cnt;

    alu_result_sel_reg #(
        .WIDTH (WIDTH),
        .NUM_IN(NUM_IN),
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_illegal(out_illegal),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cnt_clr    (cnt_clr),
        .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             ill;
    } beat_t;

    // Reference model: the stage is a FIFO of depth two plus a saturating counter.
    beat_t mq[$];
    int    mcnt = 0;

    typedef struct {
        logic             iv;
        logic [3:0]       sel;
        logic             ordy;
        logic             clr;
        logic             e_rdy;
        logic             e_ov;
        logic [WIDTH-1:0] e_data;
        logic             e_ill;
        int               e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void add(input logic iv, input int sel, input logic ordy, input logic clr,
                                input logic e_rdy, input logic e_ov, input int e_data,
                                input logic e_ill, input int e_cnt);
        vec_t v;
        v.iv = iv; v.sel = 4'(sel); v.ordy = ordy; v.clr = clr;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_data = WIDTH'(e_data);
        v.e_ill = e_ill; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endfunction

    task automatic model_check();
        chk("model in_ready", {31'b0, in_ready}, {31'b0, (mq.size() < 2)});
        chk("model out_valid", {31'b0, out_valid}, {31'b0, (mq.size() > 0)});
        if (mq.size() > 0) begin
            chk("model out_data", {24'b0, out_data}, {24'b0, mq[0].d});
            chk("model out_illegal", {31'b0, out_illegal}, {31'b0, mq[0].ill});
        end
        chk("model illegal_cnt", {30'b0, illegal_cnt}, 32'(mcnt));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input logic iv, input logic [3:0] sel, input logic ordy, input logic clr);
        bit    pop, acc;
        beat_t b;
        in_valid  = iv;
        in_sel    = sel;
        out_ready = ordy;
        cnt_clr   = clr;
        pop = (mq.size() > 0) && ordy;
        acc = iv && (mq.size() < 2);
        if (int'(sel) < NUM_IN) begin
            b.d   = in_data[int'(sel)*WIDTH +: WIDTH];
            b.ill = 1'b0;
        end else begin
            b.d   = '0;
            b.ill = 1'b1;
        end
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(b);
        if (clr) mcnt = 0;
        else if (acc && b.ill && mcnt < CNT_MAX) mcnt++;
        model_check();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        for (int k = 0; k < NUM_IN; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'(8'h10 + k);

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset out_data", {24'b0, out_data}, 32'd0);
        chk("reset out_illegal", {31'b0, out_illegal}, 32'd0);
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset illegal_cnt", {30'b0, illegal_cnt}, 32'd0);
        rst = 1'b0;

        // Streaming: channel k appears one cycle after its accept.
        for (int k = 0; k < NUM_IN; k++) add(1, k, 1, 0, 1, 1, 8'h10 + k, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0);
        // Backpressure: 3 and 5 held, 7 waits, then 13h/15h/17h back to back.
        add(1, 3, 0, 0, 1, 1, 8'h13, 0, 0);
        add(1, 5, 0, 0, 0, 1, 8'h13, 0, 0);
        add(1, 7, 0, 0, 0, 1, 8'h13, 0, 0);
        add(1, 7, 1, 0, 1, 1, 8'h15, 0, 0);
        add(1, 7, 1, 0, 1, 1, 8'h17, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0);
        // Illegal selects.
        add(1, 11, 1, 0, 1, 1, 0, 1, 1);
        add(1, 15, 1, 0, 1, 1, 0, 1, 2);
        add(0, 0, 1, 0, 1, 0, 0, 0, 2);
        // Saturation at 3, then clear wins over a same-cycle increment.
        add(0, 0, 1, 1, 1, 0, 0, 0, 0);
        add(1, 12, 1, 0, 1, 1, 0, 1, 1);
        add(1, 13, 1, 0, 1, 1, 0, 1, 2);
        add(1, 14, 1, 0, 1, 1, 0, 1, 3);
        add(1, 15, 1, 0, 1, 1, 0, 1, 3);
        add(1, 11, 1, 0, 1, 1, 0, 1, 3);
        add(1, 12, 1, 1, 1, 1, 0, 1, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].iv, tbl[i].sel, tbl[i].ordy, tbl[i].clr);
            $display("vec %0d: iv=%0b sel=%0d ordy=%0b clr=%0b -> rdy=%0b ov=%0b data=%02h ill=%0b cnt=%0d",
                     i, tbl[i].iv, tbl[i].sel, tbl[i].ordy, tbl[i].clr,
                     in_ready, out_valid, out_data, out_illegal, illegal_cnt);
            chk("tbl in_ready", {31'b0, in_ready}, {31'b0, tbl[i].e_rdy});
            chk("tbl out_valid", {31'b0, out_valid}, {31'b0, tbl[i].e_ov});
            if (tbl[i].e_ov) begin
                chk("tbl out_data", {24'b0, out_data}, {24'b0, tbl[i].e_data});
                chk("tbl out_illegal", {31'b0, out_illegal}, {31'b0, tbl[i].e_ill});
            end
            chk("tbl illegal_cnt", {30'b0, illegal_cnt}, 32'(tbl[i].e_cnt));
        end

        // Asynchronous reset with both OR and SK occupied and a nonzero count.
        step(1, 4'd3, 0, 0);
        step(1, 4'd11, 0, 0);
        chk("pre-reset in_ready", {31'b0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("async rst in_ready", {31'b0, in_ready}, 32'd1);
        chk("async rst illegal_cnt", {30'b0, illegal_cnt}, 32'd0);
        chk("async rst out_data", {24'b0, out_data}, 32'd0);
        mq.delete();
        mcnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;

        // Random traffic with fresh channel contents each cycle.
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < NUM_IN; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
            step(1'($urandom_range(1, 0)),
                 4'($urandom_range(15, 0)),
                 ($urandom_range(9, 0) < 7),
                 ($urandom_range(49, 0) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_sel_reg.md
# alu_result_sel_reg

Parametrised, registered result selector for the ALU datapath: picks one of `NUM_IN` operand/result channels of `WIDTH` bits by a binary select code, flags out-of-range codes, and delivers the selected word through a valid/ready output stage with a one-entry skid buffer. It sits between the ALU functional units and the result writeback. It replaces per-bit combinational selection with a single pipelined stage that can absorb backpressure.

## Interface
Parameters:
- `WIDTH`, 8: data width of each channel and of `out_data`.
- `NUM_IN`, 11: number of input channels; legal range 2..2^`SEL_W`.
- `SEL_W`, 4: select code width.
- `CNT_W`, 8: width of the illegal-select counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  `NUM_IN*WIDTH`  flat channel bus; channel k occupies bits [k*WIDTH +: WIDTH].
- `in_sel`  in  `SEL_W`  channel index, binary.
- `in_valid`  in  1  `in_data`/`in_sel` are valid this cycle.
- `in_ready`  out  1  stage can accept this cycle.
- `out_data`  out  `WIDTH`  selected word.
- `out_illegal`  out  1  the beat in `out_data` came from an out-of-range select.
- `out_valid`  out  1  output beat present.
- `out_ready`  in  1  downstream accepts the beat.
- `cnt_clr`  in  1  synchronous clear of `illegal_cnt`.
- `illegal_cnt`  out  `CNT_W`  saturating count of accepted illegal selects.

## Operation
- Definitions: accept = `in_valid & in_ready`; pop = `out_valid & out_ready`.
- Selection: if `in_sel < NUM_IN`, the beat's data is channel `in_sel` and illegal = 0. Otherwise the beat's data is all zeros and illegal = 1. The beat is still accepted and delivered.
- Storage: output register (OR) drives `out_*`; skid register (SK) holds data, illegal and a valid bit.
- `in_ready` = ~SK.valid. It is registered state, with no combinational path from `out_ready`.
- Per-cycle update, in priority order:
  - If SK.valid and pop: OR loads SK and SK.valid clears.
  - Else if accept and (!OR.valid or pop): OR loads the selected input beat.
  - Else if accept: SK loads the selected input beat and SK.valid sets. OR holds.
  - Else if pop: OR.valid clears.
- accept and SK.valid can never be true together, because `in_ready` is low whenever SK.valid is set.
- When no pop occurs, OR.valid, `out_data` and `out_illegal` hold stable. Data never changes while `out_valid` is high and `out_ready` is low.
- Counter: on accept with illegal = 1, `illegal_cnt` increments and saturates at 2^`CNT_W`−1. `cnt_clr` forces the counter to 0 and takes priority over a same-cycle increment.
- Ordering: beats leave in acceptance order; none are dropped or duplicated.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_illegal`=0, SK.valid=0, `in_ready`=1, `illegal_cnt`=0. Reset asserted mid-transfer discards both stored beats immediately, without waiting for a clock.
- Latency: an accept at edge N with an empty or draining OR gives `out_valid`=1 with that beat after edge N.
- Throughput: 1 beat/cycle while `out_ready` is held high.
- Backpressure: with `out_ready` low, at most 2 beats are held (OR + SK). `in_ready` falls the cycle after SK fills and rises the cycle after the pop that drains SK.
- `illegal_cnt` updates one cycle after the accepting edge. `cnt_clr` takes effect on the next edge.

## Test plan
- Reset / idle:
  - Stimulus: assert `rst` asynchronously while a beat is in OR and SK, then release.
  - Required: `out_valid`=0, `in_ready`=1, `illegal_cnt`=0 immediately, with no clock edge needed.
- Streaming:
  - Stimulus: `WIDTH`=8, `NUM_IN`=11, channel k = 8'h10+k, `out_ready`=1, `in_sel` = 0,1,…,10 on consecutive cycles.
  - Required: `out_data` = 10h..1Ah on consecutive cycles, each appearing 1 cycle after its accept, with `out_illegal`=0.
- Backpressure:
  - Stimulus: `out_ready`=0 while sending `in_sel`=3,5,7.
  - Required: beats 13h and 15h are held, `in_ready` drops after the second accept, and 7 waits at the input. Raising `out_ready` yields 13h, 15h, 17h in order with no gaps once flowing.
- Illegal select:
  - Stimulus: `in_sel`=11, then 15.
  - Required: `out_data`=00h and `out_illegal`=1 for both beats, and `illegal_cnt`=2.
- Counter saturation and clear:
  - Stimulus: `CNT_W`=2, send 5 illegal beats, then assert `cnt_clr` in the same cycle as a 6th illegal accept.
  - Required: `illegal_cnt` reads 3 after the 3rd, 4th and 5th beats, then 0 after the clear cycle.
- Random:
  - Stimulus: random `in_valid`/`out_ready`/`in_sel` over 10k cycles.
  - Required: a scoreboard confirms order, data and illegal flag for every beat; `out_data` is stable while stalled; there is no loss or duplication.
